stat_pkt_ext: RTL and testbench
===============================

STAT_PKT_EXT -- requirements
Module: stat_pkt_ext

Interface
REQ-001 Parameter: A_WIDTH, default 3, flow-number width; 2**A_WIDTH flows.
REQ-002 Parameter: SIZE_W, default 16, packet-size width.
REQ-003 Parameter: BYTE_W, default 32, per-flow byte-counter width; SHALL be >= SIZE_W.
REQ-004 Parameter: PKT_W, default 32, per-flow packet-counter width.
REQ-005 Parameter: SATURATE, default 0; 0 = counters wrap modulo 2**width, 1 = counters stick at all-ones.
REQ-006 Parameter: CLR_ON_RD, default 1; 1 = a read zeroes the flow's counters, 0 = non-destructive read.
REQ-007 clk_i  input  1  single clock; all logic on rising edge.
REQ-008 rst_i  input  1  reset, synchronous, active-low.
REQ-009 rx_flow_num_i  input  A_WIDTH  flow of the reported packet.
REQ-010 pkt_size_i  input  SIZE_W  packet size in bytes.
REQ-011 pkt_size_ena_i  input  1  update strobe; one packet per high cycle.
REQ-012 rd_stb_i  input  1  read request; one request per high cycle.
REQ-013 rd_flow_num_i  input  A_WIDTH  flow to read.
REQ-014 rd_bytes_o  output  BYTE_W  byte count of the read flow.
REQ-015 rd_pkts_o  output  PKT_W  packet count of the read flow.
REQ-016 rd_data_val_o  output  1  one-cycle pulse qualifying rd_bytes_o/rd_pkts_o.
REQ-017 init_done_o  output  1  high once counter memory is cleared; updates and reads are accepted only while high.

Function
REQ-018 Control FSM SHALL have two states, INIT and RUN; INIT walks a clear pointer 0..2**A_WIDTH-1, writing zero to both counters of each flow, one flow per cycle.
REQ-019 INIT->RUN SHALL occur after the last flow is written; init_done_o SHALL be high exactly 2**A_WIDTH cycles after the first cycle with rst_i high.
REQ-020 In INIT, pkt_size_ena_i and rd_stb_i SHALL be ignored: no update, no rd_data_val_o.
REQ-021 In RUN, a cycle with pkt_size_ena_i high SHALL add pkt_size_i to the flow's byte counter and 1 to its packet counter; size 0 still counts one packet.
REQ-022 Updates SHALL be accepted every cycle with no back-pressure, including back-to-back updates to the same flow; a forwarding path SHALL make every update count exactly once.
REQ-023 SATURATE=0: sums wrap modulo 2**BYTE_W / 2**PKT_W; SATURATE=1: each counter clamps at all-ones independently.
REQ-024 rd_data_val_o SHALL pulse exactly 2 cycles after the cycle rd_stb_i is sampled high; reads may be issued every cycle; rd_bytes_o/rd_pkts_o hold their last value when rd_data_val_o is low.
REQ-025 Ordering: a read sampled in cycle N SHALL include all updates sampled in cycles < N and exclude updates sampled in cycles >= N, for any same-flow interleaving.
REQ-026 CLR_ON_RD=1: the read flow's counters SHALL be zeroed at the read's ordering point; updates sampled in cycles >= N SHALL survive the clear and accumulate from zero.
REQ-027 An update and a read in the same cycle, same flow: the read excludes the packet; with CLR_ON_RD=1 the entry afterwards holds only that packet.
REQ-028 Updates and reads to different flows in the same cycle SHALL not interact.

Reset
REQ-029 While rst_i is low: rd_bytes_o=0, rd_pkts_o=0, rd_data_val_o=0, init_done_o=0, FSM in INIT with clear pointer 0, all in-flight updates and reads discarded.
REQ-030 Reset asserted mid-RUN or mid-INIT SHALL abort all operations and restart INIT from flow 0 after deassertion; no rd_data_val_o pulse for a discarded read.

Verification
REQ-031 Reset release, A_WIDTH=3 -> init_done_o high 8 cycles later; rd_stb_i during INIT -> no rd_data_val_o.
REQ-032 Nine back-to-back updates flow 0, size 100, ena pattern 1,1,1,1,1,1,0,1,0, then read flow 0 -> 2 cycles later rd_bytes_o=700, rd_pkts_o=7; second read -> 0/0 (CLR_ON_RD=1) or 700/7 (CLR_ON_RD=0).
REQ-033 Update flow 5 size 64 in same cycle as read flow 5, then read again -> first read 0/0, second read 64/1 (CLR_ON_RD=1).
REQ-034 BYTE_W=17, SATURATE=1, three updates flow 2 size 65535 -> read 131071/3; SATURATE=0 -> 65533/3.
REQ-035 Updates interleaved across flows 0..7 every cycle with random sizes plus reads every cycle -> all returned values match a reference model honouring REQ-025/REQ-026.
REQ-036 Reset low for 1 cycle mid-traffic with a read outstanding -> no rd_data_val_o for it, INIT reruns, all flows read 0/0 afterward.

Source files
------------

// File: rtl/stat_pkt_ext.sv
// Per-flow byte/packet statistics with clear-on-read and an INIT sweep of the counter memory.
// Two-stage pipeline: p0 holds accepted requests, p1 holds the pending write-back, forwarded into p0.
module stat_pkt_ext #(
  parameter int A_WIDTH   = 3,
  parameter int SIZE_W    = 16,
  parameter int BYTE_W    = 32,
  parameter int PKT_W     = 32,
  parameter int SATURATE  = 0,
  parameter int CLR_ON_RD = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [A_WIDTH-1:0] rx_flow_num_i,
  input  logic [SIZE_W-1:0]  pkt_size_i,
  input  logic               pkt_size_ena_i,
  input  logic               rd_stb_i,
  input  logic [A_WIDTH-1:0] rd_flow_num_i,
  output logic [BYTE_W-1:0]  rd_bytes_o,
  output logic [PKT_W-1:0]   rd_pkts_o,
  output logic               rd_data_val_o,
  output logic               init_done_o
);

  localparam int NFLOW = 1 << A_WIDTH;

  typedef enum logic {INIT, RUN} state_t;

  state_t             state, state_nxt;
  logic [A_WIDTH-1:0] clr_ptr;
  logic               init_we;
  logic               run;

  logic [BYTE_W-1:0]  bytes_mem [NFLOW];
  logic [PKT_W-1:0]   pkts_mem  [NFLOW];

  logic               upd_vld_p0, rd_vld_p0;
  logic [A_WIDTH-1:0] upd_flow_p0, rd_flow_p0;
  logic [SIZE_W-1:0]  upd_size_p0;

  logic               wr_vld_p1, clr_vld_p1;
  logic [A_WIDTH-1:0] wr_flow_p1, clr_flow_p1;
  logic [BYTE_W-1:0]  wr_bytes_p1;
  logic [PKT_W-1:0]   wr_pkts_p1;

  logic [BYTE_W-1:0]  upd_bytes_cur, rd_bytes_cur;
  logic [PKT_W-1:0]   upd_pkts_cur, rd_pkts_cur;

  function automatic logic [BYTE_W-1:0] add_bytes(input logic [BYTE_W-1:0] acc,
                                                  input logic [SIZE_W-1:0] sz);
    logic [BYTE_W:0] sum;
    sum = {1'b0, acc} + {{(BYTE_W - SIZE_W + 1){1'b0}}, sz};
    if (SATURATE != 0 && sum[BYTE_W]) return '1;
    return sum[BYTE_W-1:0];
  endfunction

  function automatic logic [PKT_W-1:0] inc_pkts(input logic [PKT_W-1:0] acc);
    if (SATURATE != 0 && acc == '1) return acc;
    return acc + PKT_W'(1);
  endfunction

  // Control FSM: state register, next state, outputs
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state   <= INIT;
      clr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) clr_ptr <= clr_ptr + A_WIDTH'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == INIT && clr_ptr == '1) state_nxt = RUN;
  end

  always_comb begin
    init_we     = (state == INIT);
    run         = (state == RUN);
    init_done_o = run;
  end

  // Stage p0: accepted requests
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      upd_vld_p0 <= 1'b0;
      rd_vld_p0  <= 1'b0;
    end else begin
      upd_vld_p0 <= pkt_size_ena_i && run;
      rd_vld_p0  <= rd_stb_i && run;
    end
  end

  always_ff @(posedge clk_i) begin
    upd_flow_p0 <= rx_flow_num_i;
    upd_size_p0 <= pkt_size_i;
    rd_flow_p0  <= rd_flow_num_i;
  end

  // Memory lags by the p1 write-back, so p1 is forwarded; a same-cycle read clears the update's base.
  always_comb begin
    upd_bytes_cur = bytes_mem[upd_flow_p0];
    upd_pkts_cur  = pkts_mem[upd_flow_p0];
    if (clr_vld_p1 && clr_flow_p1 == upd_flow_p0) begin
      upd_bytes_cur = '0;
      upd_pkts_cur  = '0;
    end
    if (wr_vld_p1 && wr_flow_p1 == upd_flow_p0) begin
      upd_bytes_cur = wr_bytes_p1;
      upd_pkts_cur  = wr_pkts_p1;
    end
    if (CLR_ON_RD != 0 && rd_vld_p0 && rd_flow_p0 == upd_flow_p0) begin
      upd_bytes_cur = '0;
      upd_pkts_cur  = '0;
    end

    rd_bytes_cur = bytes_mem[rd_flow_p0];
    rd_pkts_cur  = pkts_mem[rd_flow_p0];
    if (clr_vld_p1 && clr_flow_p1 == rd_flow_p0) begin
      rd_bytes_cur = '0;
      rd_pkts_cur  = '0;
    end
    if (wr_vld_p1 && wr_flow_p1 == rd_flow_p0) begin
      rd_bytes_cur = wr_bytes_p1;
      rd_pkts_cur  = wr_pkts_p1;
    end
  end

  // Stage p1: write-back and read result
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_vld_p1     <= 1'b0;
      clr_vld_p1    <= 1'b0;
      rd_data_val_o <= 1'b0;
      rd_bytes_o    <= '0;
      rd_pkts_o     <= '0;
    end else begin
      wr_vld_p1     <= upd_vld_p0;
      clr_vld_p1    <= rd_vld_p0 && (CLR_ON_RD != 0);
      rd_data_val_o <= rd_vld_p0;
      if (rd_vld_p0) begin
        rd_bytes_o <= rd_bytes_cur;
        rd_pkts_o  <= rd_pkts_cur;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    wr_flow_p1  <= upd_flow_p0;
    wr_bytes_p1 <= add_bytes(upd_bytes_cur, upd_size_p0);
    wr_pkts_p1  <= inc_pkts(upd_pkts_cur);
    clr_flow_p1 <= rd_flow_p0;
  end

  // Counter memory; an update write overrides a clear of the same flow
  always_ff @(posedge clk_i) begin
    if (init_we) begin
      bytes_mem[clr_ptr] <= '0;
      pkts_mem[clr_ptr]  <= '0;
    end
    if (clr_vld_p1) begin
      bytes_mem[clr_flow_p1] <= '0;
      pkts_mem[clr_flow_p1]  <= '0;
    end
    if (wr_vld_p1) begin
      bytes_mem[wr_flow_p1] <= wr_bytes_p1;
      pkts_mem[wr_flow_p1]  <= wr_pkts_p1;
    end
  end

endmodule

// File: tb/tb_stat_pkt_ext.sv
// Bench for stat_pkt_ext: per-cycle reference model plus vector table and directed corner sequences.
module tb_stat_pkt_ext;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ena, rd;
  logic [2:0]  rx_flow, rd_flow;
  logic [15:0] size;

  logic [31:0] m_bytes, m_pkts;
  logic        m_val, m_done;
  logic [31:0] n_bytes, n_pkts;
  logic        n_val, n_done;
  logic [16:0] s_bytes, w_bytes;
  logic [31:0] s_pkts, w_pkts;
  logic        s_val, s_done, w_val, w_done;

  stat_pkt_ext dut (
    .clk_i(clk), .rst_i(rst), .rx_flow_num_i(rx_flow), .pkt_size_i(size),
    .pkt_size_ena_i(ena), .rd_stb_i(rd), .rd_flow_num_i(rd_flow),
    .rd_bytes_o(m_bytes), .rd_pkts_o(m_pkts), .rd_data_val_o(m_val), .init_done_o(m_done));

  stat_pkt_ext #(.CLR_ON_RD(0)) dut_nc (
    .clk_i(clk), .rst_i(rst), .rx_flow_num_i(rx_flow), .pkt_size_i(size),
    .pkt_size_ena_i(ena), .rd_stb_i(rd), .rd_flow_num_i(rd_flow),
    .rd_bytes_o(n_bytes), .rd_pkts_o(n_pkts), .rd_data_val_o(n_val), .init_done_o(n_done));

  stat_pkt_ext #(.BYTE_W(17), .SATURATE(1)) dut_sat (
    .clk_i(clk), .rst_i(rst), .rx_flow_num_i(rx_flow), .pkt_size_i(size),
    .pkt_size_ena_i(ena), .rd_stb_i(rd), .rd_flow_num_i(rd_flow),
    .rd_bytes_o(s_bytes), .rd_pkts_o(s_pkts), .rd_data_val_o(s_val), .init_done_o(s_done));

  stat_pkt_ext #(.BYTE_W(17), .SATURATE(0)) dut_wrap (
    .clk_i(clk), .rst_i(rst), .rx_flow_num_i(rx_flow), .pkt_size_i(size),
    .pkt_size_ena_i(ena), .rd_stb_i(rd), .rd_flow_num_i(rd_flow),
    .rd_bytes_o(w_bytes), .rd_pkts_o(w_pkts), .rd_data_val_o(w_val), .init_done_o(w_done));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain per-flow totals; a read snapshots then clears, before the same-cycle update.
  typedef struct {
    int     due;
    longint b;
    longint p;
  } exp_t;

  longint mb [8];
  longint mp [8];
  exp_t   q[$];
  int     ec     = 0;
  int     since  = 0;
  longint held_b = 0;
  longint held_p = 0;

  task automatic cyc(input bit e, input bit [2:0] f, input bit [15:0] s,
                     input bit r, input bit [2:0] rf);
    exp_t x;
    bit   run_now;
    ena = e; rx_flow = f; size = s; rd = r; rd_flow = rf;
    @(posedge clk);
    ec++;
    if (!rst) begin
      since  = 0;
      held_b = 0;
      held_p = 0;
      q.delete();
      for (int i = 0; i < 8; i++) begin
        mb[i] = 0;
        mp[i] = 0;
      end
    end else begin
      run_now = (since >= 8);
      since++;
      if (run_now && r) begin
        x.due = ec + 1;
        x.b   = mb[rf];
        x.p   = mp[rf];
        q.push_back(x);
        mb[rf] = 0;
        mp[rf] = 0;
      end
      if (run_now && e) begin
        mb[f] = (mb[f] + longint'(s)) & 64'hFFFF_FFFF;
        mp[f] = (mp[f] + 1) & 64'hFFFF_FFFF;
      end
    end
    #1;
    chk("init_done", longint'(m_done), longint'(since >= 8));
    if (q.size() > 0 && q[0].due == ec) begin
      chk("rd_val", longint'(m_val), 1);
      held_b = q[0].b;
      held_p = q[0].p;
      void'(q.pop_front());
    end else begin
      chk("rd_val", longint'(m_val), 0);
    end
    chk("rd_bytes", longint'(m_bytes), held_b);
    chk("rd_pkts", longint'(m_pkts), held_p);
  endtask

  typedef struct {
    bit        e;
    bit [2:0]  f;
    bit [15:0] s;
    bit        r;
    bit [2:0]  rf;
    bit        c;
    longint    eb, ep, nb, np;
  } vec_t;

  function automatic vec_t mkv(bit e, bit [2:0] f, bit [15:0] s, bit r, bit [2:0] rf,
                               bit c, longint eb, longint ep, longint nb, longint np);
    vec_t v;
    v.e = e; v.f = f; v.s = s; v.r = r; v.rf = rf;
    v.c = c; v.eb = eb; v.ep = ep; v.nb = nb; v.np = np;
    return v;
  endfunction

  function automatic bit [2:0] rflow();
    return 3'($urandom_range(0, 7));
  endfunction

  function automatic bit [15:0] rsize();
    if ($urandom_range(0, 7) == 0) return 16'd0;
    return 16'($urandom_range(0, 65535));
  endfunction

  task automatic rand_cycles(input int n);
    for (int k = 0; k < n; k++)
      cyc($urandom_range(0, 3) != 0, rflow(), rsize(), $urandom_range(0, 2) != 0, rflow());
  endtask

  vec_t     tv [12];
  bit [8:0] pat;

  initial begin
    pat = 9'b010111111;
    for (int i = 0; i < 9; i++) tv[i] = mkv(pat[i], 3'd0, 16'd100, 1'b0, 3'd0, 1'b0, 0, 0, 0, 0);
    tv[9]  = mkv(1'b0, 3'd0, 16'd0, 1'b1, 3'd0, 1'b0, 0, 0, 0, 0);
    tv[10] = mkv(1'b0, 3'd0, 16'd0, 1'b1, 3'd0, 1'b1, 700, 7, 700, 7);
    tv[11] = mkv(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 1'b1, 0, 0, 700, 7);

    rst = 1'b0; ena = 1'b0; rd = 1'b0; rx_flow = '0; rd_flow = '0; size = '0;
    repeat (3) cyc(1'b1, 3'd1, 16'd9, 1'b1, 3'd3);

    // INIT sweep with reads and updates that must be ignored
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 3'(i), 16'd50, 1'b1, 3'(i));
      chk("init_lat", longint'(m_done), longint'(i == 7));
    end
    cyc(1'b0, 3'd0, 16'd0, 1'b0, 3'd0);
    cyc(1'b0, 3'd0, 16'd0, 1'b0, 3'd0);

    for (int i = 0; i < 12; i++) begin
      cyc(tv[i].e, tv[i].f, tv[i].s, tv[i].r, tv[i].rf);
      if (tv[i].c) begin
        chk("tbl_val", longint'(m_val), 1);
        chk("tbl_bytes", longint'(m_bytes), tv[i].eb);
        chk("tbl_pkts", longint'(m_pkts), tv[i].ep);
        chk("tbl_nc_val", longint'(n_val), 1);
        chk("tbl_nc_bytes", longint'(n_bytes), tv[i].nb);
        chk("tbl_nc_pkts", longint'(n_pkts), tv[i].np);
      end
    end

    // Same-cycle update and read on one flow
    cyc(1'b1, 3'd5, 16'd64, 1'b1, 3'd5);
    cyc(1'b0, 3'd0, 16'd0, 1'b1, 3'd5);
    chk("same_cyc_val", longint'(m_val), 1);
    chk("same_cyc_bytes", longint'(m_bytes), 0);
    chk("same_cyc_pkts", longint'(m_pkts), 0);
    cyc(1'b0, 3'd0, 16'd0, 1'b0, 3'd0);
    chk("after_clr_val", longint'(m_val), 1);
    chk("after_clr_bytes", longint'(m_bytes), 64);
    chk("after_clr_pkts", longint'(m_pkts), 1);

    // 17-bit byte counters: saturate vs wrap
    repeat (3) cyc(1'b1, 3'd2, 16'd65535, 1'b0, 3'd0);
    cyc(1'b0, 3'd0, 16'd0, 1'b1, 3'd2);
    cyc(1'b0, 3'd0, 16'd0, 1'b0, 3'd0);
    chk("wide_bytes", longint'(m_bytes), 196605);
    chk("sat_val", longint'(s_val), 1);
    chk("sat_bytes", longint'(s_bytes), 131071);
    chk("sat_pkts", longint'(s_pkts), 3);
    chk("wrap_val", longint'(w_val), 1);
    chk("wrap_bytes", longint'(w_bytes), 65533);
    chk("wrap_pkts", longint'(w_pkts), 3);

    rand_cycles(250);

    // One-cycle reset with a read in flight
    cyc(1'b1, rflow(), rsize(), 1'b1, rflow());
    rst = 1'b0;
    cyc(1'b1, rflow(), rsize(), 1'b1, rflow());
    chk("rst_val", longint'(m_val), 0);
    rst = 1'b1;
    cyc(1'b1, rflow(), rsize(), 1'b1, rflow());
    chk("rst_drop_val", longint'(m_val), 0);
    rand_cycles(7);
    for (int f = 0; f < 8; f++) cyc(1'b0, 3'd0, 16'd0, 1'b1, 3'(f));
    cyc(1'b0, 3'd0, 16'd0, 1'b0, 3'd0);
    chk("post_rst_bytes", longint'(m_bytes), 0);
    chk("post_rst_pkts", longint'(m_pkts), 0);
    cyc(1'b0, 3'd0, 16'd0, 1'b0, 3'd0);

    rand_cycles(250);
    repeat (3) cyc(1'b0, 3'd0, 16'd0, 1'b0, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
